block_exp_shift: RTL and testbench
==================================

// Module: block_exp_shift
// PURPOSE
//  Block-floating-point shift planner. Sits directly upstream of the round-to-nearest right-shift stage.
//  Buffers a block of BLK_N unsigned samples and finds their maximum.
//  Picks one shared shift so that every rounded sample fits OUT_W bits, then replays the block.
//  Each replayed sample carries the shared shift, over a valid/ready stream.
// PARAMETERS
//  IN_W     16                        input sample width (unsigned)
//  OUT_W    8                         width the downstream rounding stage must fit into; OUT_W < IN_W
//  BLK_N    8                         samples per block; >= 2
//  SHIFT_W  $clog2(IN_W-OUT_W+2)      shift field width; holds 0..IN_W-OUT_W+1
// PORTS
//  clk        in   1        clock
//  rst_b      in   1        reset, asynchronous, active-low
//  in_valid   in   1        input sample valid
//  in_ready   out  1        block accepts input
//  in_data    in   IN_W     input sample
//  out_valid  out  1        output sample valid
//  out_ready  in   1        downstream accepts output
//  out_data   out  IN_W     replayed sample, unmodified
//  out_shift  out  SHIFT_W  shared right-shift for the current block
//  out_first  out  1        first sample of block
//  out_last   out  1        last sample of block
// BEHAVIOUR
//  - Reset values:
//    - state FILL; sample count 0; running max 0.
//    - in_ready=1; out_valid=0; out_data=0; out_shift=0; out_first=0; out_last=0.
//  - Transfer rule: a transfer occurs when valid && ready on the same rising edge.
//    - valid never depends combinationally on ready.
//  - FILL:
//    - in_ready=1.
//    - Each input transfer writes buf[cnt] and updates max = max(max, in_data).
//    - On the BLK_N-th transfer, go to CALC.
//  - CALC (exactly 1 cycle): in_ready=0; out_valid=0.
//    - L = bit length of max (0 for max=0).
//    - s0 = (L>OUT_W) ? L-OUT_W : 0.
//    - s = s0+1 if s0>0 and ((max + 2^(s0-1)) >> s0) > 2^OUT_W-1; otherwise s = s0.
//    - Compute the overflow check at IN_W+1 bits; the carry must not be lost.
//    - Register s into out_shift, then go to DRAIN.
//  - DRAIN: in_ready=0; out_valid=1.
//    - Outputs: out_data=buf[idx]; out_first=(idx==0); out_last=(idx==BLK_N-1).
//    - idx advances only on an output transfer.
//    - While out_ready=0, all out_* hold stable.
//    - A transfer at idx==BLK_N-1 returns to FILL: clears count and max, in_ready=1 next cycle.
//  - Meaning of out_shift:
//    - out_shift=0 means no rounding; the downstream stage must pass data through.
//    - For s>0, the downstream result is (x + 2^(s-1)) >> s, which fits OUT_W bits for every x in the block.
//  - Latency: the first output appears 2 cycles after the last input transfer (CALC, then DRAIN registered).
//    - Throughput: one block per 2*BLK_N+1 cycles with no stalls.
//  - in_valid=0 during FILL: wait indefinitely; partial state is kept.
//  - Reset asserted mid-block: the block is discarded and reset values apply immediately (async).
//  - out_shift is stable for a whole block and may change only in CALC.
// STRUCTURE
//  - Shared package blk_fp_pkg:
//    - typedef state_e {FILL, CALC, DRAIN}.
//    - function bitlen(value) returning leading-one position + 1.
//    - function shift_for_max(max) implementing the s0/s rule.
//    - Constant MAX_SHIFT = IN_W-OUT_W+1.
//  - One sub-module, lead_one_det: a combinational priority encoder giving L, used in CALC.
//  - Sample buffer: flat register array BLK_N x IN_W; counter cnt/idx of width $clog2(BLK_N).
// TESTING (IN_W=16, OUT_W=8, BLK_N=4)
//  1. Block 3,12,9,22 -> max 22, L=5, out_shift=0; outputs 3,12,9,22 in order.
//     out_first on 3, out_last on 22.
//  2. Block 511,0,1,2 -> s0=1; (511+1)>>1=256 > 255, so out_shift=2. Data replayed unchanged.
//  3. Block 0,0,0,0 -> out_shift=0; four outputs of 0.
//  4. Block 65535,1,2,3 -> s0=8; (65535+128)>>8=256 overflows, so out_shift=9 (MAX_SHIFT).
//     Confirms no carry is lost.
//  5. Case 1 with out_ready=0 for 3 cycles after the 2nd output:
//     - out_data stays 12 with out_valid=1 and in_ready=0 throughout.
//     - Output order is preserved after release.
//  6. Reset pulse during DRAIN at idx=2:
//     - Next cycle out_valid=0, in_ready=1.
//     - New block 4,4,4,4 -> out_shift=0; no stale data is emitted.

Source files
------------

// File: rtl/blk_fp_pkg.sv
// ---------------------------------------------------------------------------
// blk_fp_pkg : shared types and shift-selection helpers for block-FP planning
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package blk_fp_pkg;

   localparam int DEF_IN_W  = 16;
   localparam int DEF_OUT_W = 8;
   localparam int MAX_SHIFT = DEF_IN_W - DEF_OUT_W + 1;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      CALC  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   function automatic logic [7:0] bitlen(input logic [31:0] value);
      logic [7:0] len;
      len = 8'd0;
      for (int i = 0; i < 32; i++) begin
         if (value[i]) len = 8'(i + 1);
      end
      return len;
   endfunction

   // Wide intermediate keeps the rounding carry out of the top sample bit.
   function automatic logic [7:0] shift_for_max(input logic [31:0] max_v,
                                                input logic [7:0]  len,
                                                input int unsigned out_w);
      logic [7:0]  s0;
      logic [63:0] sum;
      logic [63:0] lim;
      s0 = (len > 8'(out_w)) ? len - 8'(out_w) : 8'd0;
      if (s0 == 8'd0) return 8'd0;
      sum = {32'd0, max_v} + (64'd1 << (s0 - 8'd1));
      lim = (64'd1 << out_w) - 64'd1;
      return ((sum >> s0) > lim) ? s0 + 8'd1 : s0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lead_one_det.sv
// ---------------------------------------------------------------------------
// lead_one_det : combinational priority encoder, returns leading-one index + 1
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lead_one_det #(
   parameter int W     = 16,
   parameter int LEN_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     value_i,
   output logic [LEN_W-1:0] len_o
);

   always_comb begin
      len_o = '0;
      for (int i = 0; i < W; i++) begin
         if (value_i[i]) len_o = LEN_W'(i + 1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/block_exp_shift.sv
// ---------------------------------------------------------------------------
// block_exp_shift : buffers a block, picks one shared rounding shift, replays it
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module block_exp_shift
   import blk_fp_pkg::*;
#(
   parameter int IN_W    = 16,
   parameter int OUT_W   = 8,
   parameter int BLK_N   = 8,
   parameter int SHIFT_W = $clog2(IN_W - OUT_W + 2)
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IN_W-1:0]    out_data,
   output logic [SHIFT_W-1:0] out_shift,
   output logic               out_first,
   output logic               out_last
);

   localparam int              CNT_W    = $clog2(BLK_N);
   localparam int              LEN_W    = $clog2(IN_W + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_N - 1);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [IN_W-1:0]     max_q;
   logic [IN_W-1:0]     max_d;
   logic [IN_W-1:0]     sample_q [BLK_N];
   logic [LEN_W-1:0]    len;
   logic [SHIFT_W-1:0]  shift_d;

   logic                in_ready_q;
   logic                out_valid_q;
   logic [IN_W-1:0]     out_data_q;
   logic [SHIFT_W-1:0]  out_shift_q;
   logic                out_first_q;
   logic                out_last_q;

   lead_one_det #(
      .W     (IN_W),
      .LEN_W (LEN_W)
   ) u_lod (
      .value_i (max_q),
      .len_o   (len)
   );

   assign cnt_d   = cnt_q + 1'b1;
   assign max_d   = (in_data > max_q) ? in_data : max_q;
   assign shift_d = SHIFT_W'(shift_for_max(32'(max_q), 8'(len), OUT_W));

   // cnt_q is the fill pointer in FILL and the replay index in DRAIN.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         max_q       <= '0;
         for (int i = 0; i < BLK_N; i++) sample_q[i] <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_shift_q <= '0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            FILL: begin
               if (in_valid) begin
                  sample_q[cnt_q] <= in_data;
                  max_q           <= max_d;
                  if (cnt_q == LAST_IDX) begin
                     cnt_q      <= '0;
                     in_ready_q <= 1'b0;
                     state_q    <= CALC;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            CALC: begin
               out_shift_q <= shift_d;
               out_valid_q <= 1'b1;
               out_data_q  <= sample_q[0];
               out_first_q <= 1'b1;
               out_last_q  <= 1'b0;
               state_q     <= DRAIN;
            end
            DRAIN: begin
               if (out_ready) begin
                  if (cnt_q == LAST_IDX) begin
                     cnt_q       <= '0;
                     max_q       <= '0;
                     out_valid_q <= 1'b0;
                     out_first_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= FILL;
                  end else begin
                     cnt_q       <= cnt_d;
                     out_data_q  <= sample_q[cnt_d];
                     out_first_q <= 1'b0;
                     out_last_q  <= (cnt_d == LAST_IDX);
                  end
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_shift = out_shift_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_block_exp_shift.sv
// ---------------------------------------------------------------------------
// tb_block_exp_shift : directed and randomized checks of block_exp_shift
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_block_exp_shift;

   typedef logic [15:0] blk_t [4];

   logic        clk = 1'b0;
   logic        rst_b;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_shift;
   logic        out_first;
   logic        out_last;
   logic [23:0] obs;

   int errors = 0;
   int checks = 0;

   block_exp_shift #(
      .IN_W    (16),
      .OUT_W   (8),
      .BLK_N   (4),
      .SHIFT_W (4)
   ) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_shift (out_shift),
      .out_first (out_first),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   assign obs = {out_valid, in_ready, out_data, out_shift, out_first, out_last};

   // Reference: smallest shift for which every sample of the block rounds into 8 bits.
   function automatic int exp_shift(input blk_t b);
      for (int s = 0; s <= 9; s++) begin
         bit ok = 1'b1;
         for (int i = 0; i < 4; i++) begin
            longint x = longint'(b[i]);
            longint r = (s == 0) ? x : ((x + (longint'(1) << (s - 1))) >> s);
            if (r > 255) ok = 1'b0;
         end
         if (ok) return s;
      end
      return 15;
   endfunction

   task automatic feed(input blk_t b, input bit gaps);
      for (int i = 0; i < 4; i++) begin
         int t = 0;
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         in_valid = 1'b1;
         in_data  = b[i];
         while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t == 50) begin
            errors++;
            checks++;
            $display("FAIL feed_timeout sample %0d: in_ready got %b expected 1", i, in_ready);
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain(input string name, input blk_t b, input int stall_at,
                        input int stall_len, input bit rand_stall);
      int s = exp_shift(b);
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
         errors++;
         $display("FAIL %s calc_cycle: valid/ready got %b expected 00", name, {out_valid, in_ready});
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         logic [23:0] exp = {1'b1, 1'b0, b[i], 4'(s), (i == 0), (i == 3)};
         int nst = (i == stall_at) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
         out_ready = 1'b0;
         for (int k = 0; k < nst; k++) begin
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL %s hold beat %0d: got %h expected %h", name, i, obs, exp);
            end
            @(negedge clk);
         end
         out_ready = 1'b1;
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s beat %0d: got %h expected %h", name, i, obs, exp);
         end
         @(negedge clk);
         out_ready = 1'b0;
      end
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL %s return_fill: valid/ready got %b expected 01", name, {out_valid, in_ready});
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== 24'h400000) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h", obs, 24'h400000);
      end
      rst_b = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      blk_t b;
      b = '{16'd3, 16'd12, 16'd9, 16'd22};     feed(b, 0); drain("case_small", b, -1, 0, 0);
      b = '{16'd511, 16'd0, 16'd1, 16'd2};     feed(b, 0); drain("case_round_up", b, -1, 0, 0);
      b = '{16'd0, 16'd0, 16'd0, 16'd0};       feed(b, 0); drain("case_zero", b, -1, 0, 0);
      b = '{16'd65535, 16'd1, 16'd2, 16'd3};   feed(b, 0); drain("case_max_shift", b, -1, 0, 0);
   endtask

   task automatic test_stall();
      blk_t b = '{16'd3, 16'd12, 16'd9, 16'd22};
      feed(b, 0);
      drain("stall", b, 1, 3, 0);
   endtask

   task automatic test_reset_mid();
      blk_t b = '{16'd3, 16'd12, 16'd9, 16'd22};
      blk_t c = '{16'd4, 16'd4, 16'd4, 16'd4};
      feed(b, 0);
      @(negedge clk);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_data !== 16'd9) begin
         errors++;
         $display("FAIL reset_mid pre_idx2: out_data got %0d expected 9", out_data);
      end
      rst_b = 1'b0;
      #1;
      checks++;
      if (obs !== 24'h400000) begin
         errors++;
         $display("FAIL reset_mid async: got %h expected %h", obs, 24'h400000);
      end
      @(negedge clk);
      rst_b = 1'b1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL reset_mid next_cycle: valid/ready got %b expected 01", {out_valid, in_ready});
      end
      feed(c, 0);
      drain("after_reset", c, -1, 0, 0);
   endtask

   task automatic test_boundaries();
      blk_t b;
      for (int k = 1; k <= 8; k++) begin
         int v = (256 << k) - (1 << (k - 1));
         b = '{16'(v), 16'd0, 16'(v - 1), 16'd1};
         feed(b, 0); drain("edge_over", b, -1, 0, 0);
         b = '{16'd5, 16'(v - 1), 16'd0, 16'd2};
         feed(b, 0); drain("edge_fit", b, -1, 0, 0);
      end
   endtask

   task automatic test_random();
      blk_t b;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 4; i++) b[i] = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
         feed(b, n[0]);
         drain("random", b, -1, 0, n[1]);
      end
   endtask

   task automatic test_back_to_back();
      blk_t b;
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 4; i++) b[i] = 16'($urandom_range(0, 1023) << n);
         feed(b, 0);
         drain("back_to_back", b, -1, 0, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_b     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_directed();
      test_stall();
      test_reset_mid();
      test_boundaries();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
